alu_ctrl: RTL and testbench
===========================

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port instr_valid, input, 1 bit: instr holds an instruction to issue.
REQ-004 SHALL have port instr_ready, output, 1 bit: block accepts an instruction this cycle.
REQ-005 SHALL have port instr, input, 32 bits: MIPS-format instruction word.
REQ-006 SHALL have ports alu_a and alu_b, output, 32 bits each: operands driven to the external ALU.
REQ-007 SHALL have port alu_op, output, 3 bits: ALU operation code (000 add, 001 sub, 010 and, 011 or, 100 logical right shift, 101 arithmetic right shift).
REQ-008 SHALL have port alu_c, input, 32 bits: combinational result returned by the ALU.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse at writeback.
REQ-010 SHALL have port err, output, 1 bit: one-cycle pulse on an illegal instruction.
REQ-011 SHALL have ports wb_addr (output, 5 bits) and wb_data (output, 32 bits): destination register and value, valid while done=1.
REQ-012 SHALL have ports dbg_addr (input, 5 bits) and dbg_data (output, 32 bits): combinational register-file read.

Function
REQ-013 SHALL contain a 32x32 register file; register 0 SHALL always read 0 and ignore writes.
REQ-014 SHALL implement a four-state FSM: IDLE, DECODE, EXEC, WB.
REQ-015 IDLE: instr_ready=1; when instr_valid=1 the block SHALL latch instr and move to DECODE; in every other state instr_ready=0.
REQ-016 DECODE, R-type (op=000000), selected by funct: 100001 addu->000; 100011 subu->001; 100100 and->010; 100101 or->011; destination rd; alu_a=rf[rs], alu_b=rf[rt].
REQ-017 DECODE, I-type ori (op=001101): alu_op=011, alu_a=rf[rs], alu_b={16'b0, imm}, destination rt.
REQ-018 DECODE, any other op/funct: illegal; err SHALL pulse in the following cycle, no write SHALL occur, and the FSM SHALL return to IDLE.
REQ-019 alu_a, alu_b and alu_op SHALL be registered; they are loaded on DECODE exit and held until the next load.
REQ-020 EXEC: the block SHALL capture alu_c into a result register at the end of the cycle, then move to WB.
REQ-021 WB: the block SHALL write the result to the destination register (suppressed if the destination is 0), pulse done=1 with wb_addr/wb_data, then move to IDLE.
REQ-022 Latency: an instruction accepted at edge T SHALL assert done in the cycle following edge T+3; the next acceptance SHALL occur at T+4 at the earliest.
REQ-023 Writeback to register 0 SHALL still pulse done, with wb_addr=0 and wb_data set to the ALU result.
REQ-024 dbg_data SHALL reflect a write on the edge after WB.

Reset
REQ-025 When reset_n=0 at a clock edge, in any state, the block SHALL go to IDLE, clear all registers, and drive alu_a=0, alu_b=0, alu_op=000, done=0, err=0, wb_addr=0, wb_data=0.
REQ-026 An instruction in flight during reset SHALL be discarded with no write, done or err.
REQ-027 instr_ready SHALL be 1 in the first cycle after reset_n is released.

Configuration
REQ-028 With macro ALU_CTRL_SHIFT_EN defined, R-type funct 000110 srlv SHALL map to 100 and funct 000111 srav to 101, with alu_a=rf[rt], alu_b=rf[rs], destination rd.
REQ-029 Without ALU_CTRL_SHIFT_EN, funct 000110 and 000111 SHALL be illegal per REQ-018.

Verification
REQ-030 Reset, then ori $1,$0,0x1234 -> done with wb_addr=1, wb_data=0x00001234, exactly 4 cycles after acceptance.
REQ-031 $1=5, $2=7 (via ori); subu $3,$1,$2 -> wb_data=0xFFFFFFFE; dbg_addr=3 reads 0xFFFFFFFE.
REQ-032 addu $0,$1,$2 with $1=5, $2=7 -> done, wb_addr=0, wb_data=12; dbg_addr=0 reads 0.
REQ-033 instr=0xFC000000 (op 111111) -> err pulses once, no done, registers unchanged, instr_ready=1 two cycles after acceptance.
REQ-034 With ALU_CTRL_SHIFT_EN, $1=4, $2=0x80000000: srav $3,$2,$1 -> 0xF8000000; srlv -> 0x08000000. Without the macro, both -> err.
REQ-035 Assert reset_n=0 while in EXEC -> no done, all registers read 0, instr_ready=1 after release.

Source files
------------

// File: rtl/alu_ctrl.sv
// ============================================================================
// alu_ctrl : MIPS-subset issue/decode/writeback controller for an external ALU
// Option   : define ALU_CTRL_SHIFT_EN to decode srlv/srav.   Revision: 1.0
// ============================================================================
`default_nettype none

module alu_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_c,
    output logic        done,
    output logic        err,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] instr_q;
    logic [31:0] rf [32];
    logic [31:0] result;
    logic [4:0]  dest;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic        dec_legal;
    logic [2:0]  dec_op;
    logic [31:0] dec_a, dec_b;
    logic [4:0]  dec_dest;

    assign opcode   = instr_q[31:26];
    assign rs       = instr_q[25:21];
    assign rt       = instr_q[20:16];
    assign rd       = instr_q[15:11];
    assign funct    = instr_q[5:0];

    // Entry 0 is never written, so it always reads zero.
    assign dbg_data    = rf[dbg_addr];
    assign instr_ready = (state == IDLE);

    always_comb begin
        dec_legal = 1'b0;
        dec_op    = 3'b000;
        dec_a     = rf[rs];
        dec_b     = rf[rt];
        dec_dest  = rd;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100001: begin dec_legal = 1'b1; dec_op = 3'b000; end
                    6'b100011: begin dec_legal = 1'b1; dec_op = 3'b001; end
                    6'b100100: begin dec_legal = 1'b1; dec_op = 3'b010; end
                    6'b100101: begin dec_legal = 1'b1; dec_op = 3'b011; end
`ifdef ALU_CTRL_SHIFT_EN
                    // Shifts put the value in alu_a and the amount in alu_b.
                    6'b000110: begin
                        dec_legal = 1'b1; dec_op = 3'b100;
                        dec_a = rf[rt]; dec_b = rf[rs];
                    end
                    6'b000111: begin
                        dec_legal = 1'b1; dec_op = 3'b101;
                        dec_a = rf[rt]; dec_b = rf[rs];
                    end
`endif
                    default: dec_legal = 1'b0;
                endcase
            end
            6'b001101: begin
                dec_legal = 1'b1;
                dec_op    = 3'b011;
                dec_b     = {16'h0000, instr_q[15:0]};
                dec_dest  = rt;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (instr_valid) state_nxt = DECODE;
            DECODE:  state_nxt = dec_legal ? EXEC : IDLE;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            instr_q <= 32'h0;
            alu_a   <= 32'h0;
            alu_b   <= 32'h0;
            alu_op  <= 3'b000;
            result  <= 32'h0;
            dest    <= 5'd0;
            done    <= 1'b0;
            err     <= 1'b0;
            wb_addr <= 5'd0;
            wb_data <= 32'h0;
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: if (instr_valid) instr_q <= instr;
                DECODE: begin
                    if (dec_legal) begin
                        alu_a  <= dec_a;
                        alu_b  <= dec_b;
                        alu_op <= dec_op;
                        dest   <= dec_dest;
                    end else begin
                        err <= 1'b1;
                    end
                end
                EXEC: result <= alu_c;
                WB: begin
                    if (dest != 5'd0) rf[dest] <= result;
                    done    <= 1'b1;
                    wb_addr <= dest;
                    wb_data <= result;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl.sv
// ============================================================================
// tb_alu_ctrl : directed + randomized self-checking bench for alu_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_ctrl;

`ifdef ALU_CTRL_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_a, alu_b, alu_c, wb_data, dbg_data;
    logic [2:0]  alu_op;
    logic        done, err;
    logic [4:0]  wb_addr, dbg_addr;

    logic [31:0] model_rf [32];
    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu_ctrl dut (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_c(alu_c), .done(done), .err(err),
        .wb_addr(wb_addr), .wb_data(wb_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // External ALU behaviour
    always_comb begin
        case (alu_op)
            3'b000:  alu_c = alu_a + alu_b;
            3'b001:  alu_c = alu_a - alu_b;
            3'b010:  alu_c = alu_a & alu_b;
            3'b011:  alu_c = alu_a | alu_b;
            3'b100:  alu_c = alu_a >> alu_b[4:0];
            3'b101:  alu_c = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            default: alu_c = 32'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'($urandom), fn};
    endfunction

    function automatic logic [31:0] ori(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
        return {6'b001101, rs, rt, imm};
    endfunction

    task automatic check_rf(input string tag);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            chk(tag, dbg_data, model_rf[i]);
        end
    endtask

    // Issue one instruction and check its whole lifetime against the model.
    task automatic issue(input logic [31:0] ins);
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, dst;
        logic [31:0] a, b, val;
        logic        legal;
        int done_at, err_at, done_cnt, err_cnt, ready_at;
        logic [4:0]  got_addr;
        logic [31:0] got_data;
        op = ins[31:26]; fn = ins[5:0]; rs = ins[25:21]; rt = ins[20:16];
        a = model_rf[rs]; b = model_rf[rt];
        dst = ins[15:11]; legal = 1'b0; val = 32'h0;
        if (op == 6'd0) begin
            case (fn)
                6'h21: begin legal = 1'b1; val = a + b; end
                6'h23: begin legal = 1'b1; val = a - b; end
                6'h24: begin legal = 1'b1; val = a & b; end
                6'h25: begin legal = 1'b1; val = a | b; end
                6'h06: begin legal = SHIFT_EN; val = b >> a[4:0]; end
                6'h07: begin legal = SHIFT_EN; val = $unsigned($signed(b) >>> a[4:0]); end
                default: legal = 1'b0;
            endcase
        end else if (op == 6'h0D) begin
            legal = 1'b1; dst = rt; val = a | {16'h0, ins[15:0]};
        end

        @(negedge clk);
        chk("ready_before_issue", instr_ready, 1'b1);
        instr = ins; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0; instr = $urandom;
        done_at = 0; err_at = 0; done_cnt = 0; err_cnt = 0; ready_at = 0;
        got_addr = 5'd0; got_data = 32'h0;
        for (int n = 1; n <= 6; n++) begin
            if (n > 1) @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) begin done_at = n; got_addr = wb_addr; got_data = wb_data; end
            end
            if (err === 1'b1) begin err_cnt++; if (err_at == 0) err_at = n; end
            if (instr_ready === 1'b1 && ready_at == 0) ready_at = n;
        end
        if (legal) begin
            chk("done_latency", done_at, 4);
            chk("done_pulses", done_cnt, 1);
            chk("no_err", err_cnt, 0);
            chk("wb_addr", got_addr, dst);
            chk("wb_data", got_data, val);
            chk("ready_after_wb", ready_at, 4);
            if (dst != 5'd0) model_rf[dst] = val;
        end else begin
            chk("err_cycle", err_at, 2);
            chk("err_pulses", err_cnt, 1);
            chk("no_done", done_cnt, 0);
            chk("ready_after_err", ready_at, 2);
        end
        dbg_addr = dst;
        #1;
        chk("dbg_dest", dbg_data, model_rf[dst]);
    endtask

    initial begin
        logic [31:0] ins;
        int seen_done;
        reset_n = 1'b0; instr_valid = 1'b0; instr = 32'h0; dbg_addr = 5'd0;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_b", alu_b, 32'h0);
        chk("rst_alu_op", alu_op, 3'b000);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_wb_addr", wb_addr, 5'd0);
        chk("rst_wb_data", wb_data, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", instr_ready, 1'b1);

        // ori / subu / writeback to $0
        issue(ori(5'd0, 5'd1, 16'h1234));
        issue(ori(5'd0, 5'd1, 16'h0005));
        issue(ori(5'd0, 5'd2, 16'h0007));
        issue(rtype(5'd1, 5'd2, 5'd3, 6'h23));
        chk("subu_value", model_rf[3], 32'hFFFFFFFE);
        issue(rtype(5'd1, 5'd2, 5'd0, 6'h21));
        check_rf("rf_after_wr0");

        // Illegal opcode leaves the register file untouched
        issue(32'hFC000000);
        check_rf("rf_after_illegal");

        // Build $2 = 0x80000000, then the shift pair
        issue(ori(5'd0, 5'd1, 16'h0004));
        issue(ori(5'd0, 5'd2, 16'h8000));
        repeat (16) issue(rtype(5'd2, 5'd2, 5'd2, 6'h21));
        chk("build_msb", model_rf[2], 32'h80000000);
        issue(rtype(5'd1, 5'd2, 5'd3, 6'h07));
        if (SHIFT_EN) chk("srav_model", model_rf[3], 32'hF8000000);
        issue(rtype(5'd1, 5'd2, 5'd4, 6'h06));
        if (SHIFT_EN) chk("srlv_model", model_rf[4], 32'h08000000);

        // Randomized instruction mix
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 6))
                0: ins = rtype(5'($urandom), 5'($urandom), 5'($urandom), 6'h21);
                1: ins = rtype(5'($urandom), 5'($urandom), 5'($urandom), 6'h23);
                2: ins = rtype(5'($urandom), 5'($urandom), 5'($urandom), 6'h24);
                3: ins = rtype(5'($urandom), 5'($urandom), 5'($urandom), 6'h25);
                4: ins = ori(5'($urandom), 5'($urandom), 16'($urandom));
                5: ins = rtype(5'($urandom), 5'($urandom), 5'($urandom),
                               ($urandom_range(0, 1) == 0) ? 6'h06 : 6'h07);
                default: begin
                    ins = $urandom;
                    if (ins[31:26] == 6'h0D) ins[31:26] = 6'h0E;
                    if (ins[31:26] == 6'h00) ins[5:0] = 6'h3F;
                end
            endcase
            issue(ins);
        end
        check_rf("rf_after_random");

        // Reset while in EXEC discards the instruction
        @(negedge clk);
        instr = ori(5'd0, 5'd5, 16'hABCD); instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("exec_rst_alu_a", alu_a, 32'h0);
        chk("exec_rst_alu_op", alu_op, 3'b000);
        chk("exec_rst_wb_data", wb_data, 32'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
        @(negedge clk);
        chk("ready_after_exec_rst", instr_ready, 1'b1);
        seen_done = 0;
        for (int n = 0; n < 5; n++) begin
            if (done === 1'b1 || err === 1'b1) seen_done++;
            @(negedge clk);
        end
        chk("no_done_after_rst", seen_done, 0);
        check_rf("rf_after_exec_rst");
        issue(ori(5'd0, 5'd6, 16'h5A5A));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
